// File: rtl/hist_input_arbiter.sv
// hist_input_arbiter
// Front-end for the histogramming core. Two sample sources share the core's
// single write port under round-robin arbitration, and the block steps the
// core through frames: accept FRAME_LEN samples, stop writing, watch the bin
// readout stream until its last bin, then re-arm (or go idle).
module hist_input_arbiter #(
    parameter int DATA_W    = 16,
    parameter int FRAME_LEN = 256,
    parameter int CNT_W     = 16,
    parameter int BIN_W     = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              req0_valid,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    input  logic              hist_ready,
    output logic              hist_write_en,
    output logic [DATA_W-1:0] hist_data,
    input  logic              hist_valid_out,
    input  logic              hist_last_bin,
    output logic              frame_active,
    output logic              frame_done,
    output logic [CNT_W-1:0]  src0_count,
    output logic [CNT_W-1:0]  src1_count,
    output logic [BIN_W-1:0]  bins_seen,
    output logic              proto_err
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCEPT  = 2'd1,
        ST_DRAIN   = 2'd2,
        ST_READOUT = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] FRAME_LEN_C = CNT_W'(FRAME_LEN);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
    localparam logic [BIN_W-1:0] BIN_ONE     = BIN_W'(1);
    localparam logic [BIN_W-1:0] BIN_MAX     = {BIN_W{1'b1}};

    state_t             state_q, state_d;
    logic               last_grant_q, last_grant_d;
    logic [CNT_W-1:0]   sample_cnt_q, sample_cnt_d;
    logic [CNT_W-1:0]   src0_cnt_q, src0_cnt_d;
    logic [CNT_W-1:0]   src1_cnt_q, src1_cnt_d;
    logic [BIN_W-1:0]   bins_q, bins_d;
    logic               write_en_q, write_en_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic               done_q, done_d;
    logic               perr_q, perr_d;

    logic               grant0;
    logic               grant1;
    logic               grant_any;
    logic [CNT_W-1:0]   sample_cnt_inc;
    logic [CNT_W-1:0]   src0_cnt_sat;
    logic [CNT_W-1:0]   src1_cnt_sat;
    logic [BIN_W-1:0]   bins_sat;

    // Round-robin grant: a tie goes to the source that did not win last time.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state_q == ST_ACCEPT && hist_ready) begin
            if (req0_valid && req1_valid) begin
                grant0 = last_grant_q;
                grant1 = ~last_grant_q;
            end else begin
                grant0 = req0_valid;
                grant1 = req1_valid;
            end
        end
        grant_any = grant0 | grant1;
    end

    // Saturating / plain increments used by the next-state logic.
    always_comb begin
        sample_cnt_inc = sample_cnt_q + CNT_ONE;
        src0_cnt_sat   = (src0_cnt_q == CNT_MAX) ? src0_cnt_q : src0_cnt_q + CNT_ONE;
        src1_cnt_sat   = (src1_cnt_q == CNT_MAX) ? src1_cnt_q : src1_cnt_q + CNT_ONE;
        bins_sat       = (bins_q == BIN_MAX) ? bins_q : bins_q + BIN_ONE;
    end

    // Frame sequencing, counters, write path and error flag.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        sample_cnt_d = sample_cnt_q;
        src0_cnt_d   = src0_cnt_q;
        src1_cnt_d   = src1_cnt_q;
        bins_d       = bins_q;
        perr_d       = perr_q;
        done_d       = 1'b0;

        // Write strobe follows the grant by one cycle; data holds otherwise.
        write_en_d = grant_any;
        if (grant0) begin
            data_d = req0_data;
        end else if (grant1) begin
            data_d = req1_data;
        end else begin
            data_d = data_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (hist_valid_out) begin
                    perr_d = 1'b1;
                end
                if (enable) begin
                    state_d      = ST_ACCEPT;
                    sample_cnt_d = '0;
                    src0_cnt_d   = '0;
                    src1_cnt_d   = '0;
                    bins_d       = '0;
                end
            end

            ST_ACCEPT: begin
                // Readout activity while samples are still going in is illegal.
                if (hist_valid_out) begin
                    perr_d = 1'b1;
                end
                if (grant_any) begin
                    sample_cnt_d = sample_cnt_inc;
                    last_grant_d = grant1;
                    if (grant0) begin
                        src0_cnt_d = src0_cnt_sat;
                    end
                    if (grant1) begin
                        src1_cnt_d = src1_cnt_sat;
                    end
                    if (sample_cnt_inc == FRAME_LEN_C) begin
                        state_d = ST_DRAIN;
                    end
                end
            end

            ST_DRAIN: begin
                // The first bin of the readout is counted here as well.
                if (hist_valid_out) begin
                    bins_d = bins_sat;
                    if (hist_last_bin) begin
                        done_d = 1'b1;
                        if (enable) begin
                            state_d      = ST_ACCEPT;
                            sample_cnt_d = '0;
                            src0_cnt_d   = '0;
                            src1_cnt_d   = '0;
                            bins_d       = '0;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        state_d = ST_READOUT;
                    end
                end
            end

            ST_READOUT: begin
                if (hist_valid_out) begin
                    bins_d = bins_sat;
                    if (hist_last_bin) begin
                        done_d = 1'b1;
                        if (enable) begin
                            state_d      = ST_ACCEPT;
                            sample_cnt_d = '0;
                            src0_cnt_d   = '0;
                            src1_cnt_d   = '0;
                            bins_d       = '0;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any frame immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            sample_cnt_q <= '0;
            src0_cnt_q   <= '0;
            src1_cnt_q   <= '0;
            bins_q       <= '0;
            write_en_q   <= 1'b0;
            data_q       <= '0;
            done_q       <= 1'b0;
            perr_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            sample_cnt_q <= sample_cnt_d;
            src0_cnt_q   <= src0_cnt_d;
            src1_cnt_q   <= src1_cnt_d;
            bins_q       <= bins_d;
            write_en_q   <= write_en_d;
            data_q       <= data_d;
            done_q       <= done_d;
            perr_q       <= perr_d;
        end
    end

    // Output mapping.
    always_comb begin
        req0_ready    = grant0;
        req1_ready    = grant1;
        hist_write_en = write_en_q;
        hist_data     = data_q;
        frame_active  = (state_q != ST_IDLE);
        frame_done    = done_q;
        src0_count    = src0_cnt_q;
        src1_count    = src1_cnt_q;
        bins_seen     = bins_q;
        proto_err     = perr_q;
    end

endmodule

// File: tb/tb_hist_input_arbiter.sv
// Self-checking bench for hist_input_arbiter with a behavioural frame model.
module tb_hist_input_arbiter;

    localparam int DW = 16;
    localparam int FL = 4;
    localparam int CW = 16;
    localparam int BW = 3;

    localparam int P_IDLE    = 0;
    localparam int P_ACCEPT  = 1;
    localparam int P_DRAIN   = 2;
    localparam int P_READOUT = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic          req0_valid = 1'b0;
    logic [DW-1:0] req0_data = '0;
    logic          req0_ready;
    logic          req1_valid = 1'b0;
    logic [DW-1:0] req1_data = '0;
    logic          req1_ready;
    logic          hist_ready = 1'b0;
    logic          hist_write_en;
    logic [DW-1:0] hist_data;
    logic          hist_valid_out = 1'b0;
    logic          hist_last_bin = 1'b0;
    logic          frame_active;
    logic          frame_done;
    logic [CW-1:0] src0_count;
    logic [CW-1:0] src1_count;
    logic [BW-1:0] bins_seen;
    logic          proto_err;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int            m_phase;
    logic          m_last;
    int            m_cnt;
    int            m_c0;
    int            m_c1;
    int            m_bins;
    logic          m_done;
    logic          m_perr;
    logic          m_we;
    logic [DW-1:0] m_data;

    hist_input_arbiter #(
        .DATA_W(DW), .FRAME_LEN(FL), .CNT_W(CW), .BIN_W(BW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
        .hist_ready(hist_ready), .hist_write_en(hist_write_en), .hist_data(hist_data),
        .hist_valid_out(hist_valid_out), .hist_last_bin(hist_last_bin),
        .frame_active(frame_active), .frame_done(frame_done),
        .src0_count(src0_count), .src1_count(src1_count),
        .bins_seen(bins_seen), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_phase = P_IDLE;
        m_last  = 1'b1;
        m_cnt   = 0;
        m_c0    = 0;
        m_c1    = 0;
        m_bins  = 0;
        m_done  = 1'b0;
        m_perr  = 1'b0;
        m_we    = 1'b0;
        m_data  = '0;
    endtask

    task automatic clear_frame();
        m_cnt  = 0;
        m_c0   = 0;
        m_c1   = 0;
        m_bins = 0;
    endtask

    // One clock cycle: drive inputs, compare grants, advance model, compare registers.
    task automatic step(input logic e, input logic v0, input logic [DW-1:0] d0,
                        input logic v1, input logic [DW-1:0] d1,
                        input logic hr, input logic hv, input logic hl);
        logic g0;
        logic g1;
        bit   fin;
        enable = e; req0_valid = v0; req0_data = d0; req1_valid = v1; req1_data = d1;
        hist_ready = hr; hist_valid_out = hv; hist_last_bin = hl;
        #2;
        g0 = (m_phase == P_ACCEPT) && hr && v0 && (!v1 || m_last == 1'b1);
        g1 = (m_phase == P_ACCEPT) && hr && v1 && (!v0 || m_last == 1'b0);
        checks++; if (req0_ready !== g0) begin errors++; $display("FAIL req0_ready got %b want %b t=%0t", req0_ready, g0, $time); end
        checks++; if (req1_ready !== g1) begin errors++; $display("FAIL req1_ready got %b want %b t=%0t", req1_ready, g1, $time); end

        m_we = g0 | g1;
        if (g0) m_data = d0;
        else if (g1) m_data = d1;
        m_done = 1'b0;
        fin = 1'b0;
        case (m_phase)
            P_IDLE: begin
                if (hv) m_perr = 1'b1;
                if (e) begin m_phase = P_ACCEPT; clear_frame(); end
            end
            P_ACCEPT: begin
                if (hv) m_perr = 1'b1;
                if (g0 || g1) begin
                    m_cnt++;
                    m_last = g1;
                    if (g0 && m_c0 < (1 << CW) - 1) m_c0++;
                    if (g1 && m_c1 < (1 << CW) - 1) m_c1++;
                    if (m_cnt == FL) m_phase = P_DRAIN;
                end
            end
            P_DRAIN: begin
                if (hv) begin
                    if (m_bins < (1 << BW) - 1) m_bins++;
                    if (hl) fin = 1'b1; else m_phase = P_READOUT;
                end
            end
            default: begin
                if (hv) begin
                    if (m_bins < (1 << BW) - 1) m_bins++;
                    if (hl) fin = 1'b1;
                end
            end
        endcase
        if (fin) begin
            m_done = 1'b1;
            if (e) begin m_phase = P_ACCEPT; clear_frame(); end
            else m_phase = P_IDLE;
        end

        @(posedge clk);
        #1;
        checks++; if (hist_write_en !== m_we) begin errors++; $display("FAIL hist_write_en got %b want %b t=%0t", hist_write_en, m_we, $time); end
        checks++; if (hist_data !== m_data) begin errors++; $display("FAIL hist_data got %h want %h t=%0t", hist_data, m_data, $time); end
        checks++; if (src0_count !== CW'(m_c0)) begin errors++; $display("FAIL src0_count got %0d want %0d t=%0t", src0_count, m_c0, $time); end
        checks++; if (src1_count !== CW'(m_c1)) begin errors++; $display("FAIL src1_count got %0d want %0d t=%0t", src1_count, m_c1, $time); end
        checks++; if (bins_seen !== BW'(m_bins)) begin errors++; $display("FAIL bins_seen got %0d want %0d t=%0t", bins_seen, m_bins, $time); end
        checks++; if (frame_done !== m_done) begin errors++; $display("FAIL frame_done got %b want %b t=%0t", frame_done, m_done, $time); end
        checks++; if (proto_err !== m_perr) begin errors++; $display("FAIL proto_err got %b want %b t=%0t", proto_err, m_perr, $time); end
        checks++; if (frame_active !== (m_phase != P_IDLE)) begin errors++; $display("FAIL frame_active got %b want %b t=%0t", frame_active, (m_phase != P_IDLE), $time); end
    endtask

    task automatic idle_step(input logic e);
        step(e, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (hist_write_en !== 1'b0 || frame_active !== 1'b0 || frame_done !== 1'b0) begin errors++; $display("FAIL reset_ctrl got we=%b fa=%b fd=%b want 0", hist_write_en, frame_active, frame_done); end
        checks++; if (src0_count !== '0 || src1_count !== '0 || bins_seen !== '0 || proto_err !== 1'b0 || hist_data !== '0) begin errors++; $display("FAIL reset_vals got c0=%0d c1=%0d b=%0d pe=%b d=%h want 0", src0_count, src1_count, bins_seen, proto_err, hist_data); end
        rst_n = 1'b1;
        model_reset();
        idle_step(1'b0);
        $display("test_reset done");
    endtask

    task automatic test_alternate();
        logic [DW-1:0] want;
        idle_step(1'b1);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1, 16'h1110, 1'b1, 16'h2220, 1'b1, 1'b0, 1'b0);
            want = (i % 2 == 0) ? 16'h1110 : 16'h2220;
            checks++; if (hist_data !== want || hist_write_en !== 1'b1) begin errors++; $display("FAIL alt_data[%0d] got %h/%b want %h/1", i, hist_data, hist_write_en, want); end
        end
        checks++; if (src0_count !== 16'd2 || src1_count !== 16'd2) begin errors++; $display("FAIL alt_counts got %0d/%0d want 2/2", src0_count, src1_count); end
        step(1'b0, 1'b0, '0, 1'b0, '0, 1'b1, 1'b1, 1'b1);
        idle_step(1'b0);
        $display("test_alternate done");
    endtask

    task automatic test_single_source();
        int grants;
        grants = 0;
        idle_step(1'b1);
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b1, DW'(16'hA0 + i), 1'b0, '0, 1'b1, 1'b0, 1'b0);
            if (hist_write_en) grants++;
        end
        checks++; if (grants != 4) begin errors++; $display("FAIL single_writes got %0d want 4", grants); end
        checks++; if (src0_count !== 16'd4 || src1_count !== 16'd0) begin errors++; $display("FAIL single_counts got %0d/%0d want 4/0", src0_count, src1_count); end
        checks++; if (frame_active !== 1'b1) begin errors++; $display("FAIL single_drain got fa=%b want 1", frame_active); end
        $display("test_single_source done");
    endtask

    task automatic test_readout();
        int pulses;
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b1, (i == 4));
            if (frame_done) pulses++;
        end
        idle_step(1'b0);
        if (frame_done) pulses++;
        checks++; if (pulses != 1) begin errors++; $display("FAIL readout_pulses got %0d want 1", pulses); end
        checks++; if (bins_seen !== 3'd5 || frame_active !== 1'b0) begin errors++; $display("FAIL readout_end got bins=%0d fa=%b want 5/0", bins_seen, frame_active); end
        $display("test_readout done");
    endtask

    task automatic test_ready_toggle();
        idle_step(1'b1);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, DW'(16'h3000 + i), 1'b1, DW'(16'h4000 + i), (i % 2 == 0), 1'b0, 1'b0);
            if (i % 2 == 1) begin
                checks++; if (hist_write_en !== 1'b0) begin errors++; $display("FAIL toggle_we[%0d] got %b want 0", i, hist_write_en); end
            end
        end
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b1, (i == 9));
        end
        checks++; if (bins_seen !== 3'd7) begin errors++; $display("FAIL bins_saturate got %0d want 7", bins_seen); end
        $display("test_ready_toggle done");
    endtask

    task automatic test_protocol();
        idle_step(1'b1);
        step(1'b0, 1'b0, '0, 1'b0, '0, 1'b1, 1'b1, 1'b0);
        checks++; if (proto_err !== 1'b1 || bins_seen !== 3'd0) begin errors++; $display("FAIL proto_set got pe=%b bins=%0d want 1/0", proto_err, bins_seen); end
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, DW'(i), 1'b0, '0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, '0, 1'b0, '0, 1'b0, 1'b1, 1'b1);
        checks++; if (proto_err !== 1'b1 || frame_active !== 1'b1) begin errors++; $display("FAIL proto_sticky got pe=%b fa=%b want 1/1", proto_err, frame_active); end
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, '0, 1'b1, DW'(i + 8), 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b1, 1'b1);
        idle_step(1'b0);
        $display("test_protocol done");
    endtask

    task automatic test_random();
        logic hv;
        for (int i = 0; i < 400; i++) begin
            hv = ($urandom_range(0, 3) == 0);
            step(($urandom_range(0, 3) != 0), $urandom_range(0, 1), DW'($urandom),
                 $urandom_range(0, 1), DW'($urandom), $urandom_range(0, 1),
                 hv, hv && ($urandom_range(0, 2) == 0));
        end
        $display("test_random done");
    endtask

    task automatic test_mid_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        idle_step(1'b1);
        step(1'b0, 1'b1, 16'h5555, 1'b1, 16'h6666, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 16'h5555, 1'b1, 16'h6666, 1'b1, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        checks++; if (hist_write_en !== 1'b0 || frame_active !== 1'b0 || hist_data !== '0) begin errors++; $display("FAIL async_reset got we=%b fa=%b d=%h want 0", hist_write_en, frame_active, hist_data); end
        checks++; if (src0_count !== '0 || src1_count !== '0 || proto_err !== 1'b0) begin errors++; $display("FAIL async_counts got %0d/%0d pe=%b want 0", src0_count, src1_count, proto_err); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        idle_step(1'b1);
        step(1'b0, 1'b1, 16'h7777, 1'b1, 16'h8888, 1'b1, 1'b0, 1'b0);
        checks++; if (src0_count !== 16'd1 || src1_count !== 16'd0 || hist_data !== 16'h7777) begin errors++; $display("FAIL post_reset_tie got %0d/%0d d=%h want 1/0 7777", src0_count, src1_count, hist_data); end
        $display("test_mid_reset done");
    endtask

    initial begin
        model_reset();
        test_reset();
        test_alternate();
        test_single_source();
        test_readout();
        test_ready_toggle();
        test_protocol();
        test_random();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hist_input_arbiter.md
Name: hist_input_arbiter

Overview:
- Front-end controller for the `histogramming` core.
- Shares the core's single sample-write port between two sample sources using round-robin arbitration.
- Sequences the core through frames: accept `FRAME_LEN` samples, stop writing, monitor the bin readout stream to its last bin, then re-arm.
- Sits between the sample producers and the core's `data_in` / `write_en` / `ready` / `valid_out` / `last_bin` ports.

Parameters:
- DATA_W, 16, sample width; matches core `data_in`.
- FRAME_LEN, 256, samples written to the core per frame (1..2^CNT_W-1).
- CNT_W, 16, width of sample and per-source counters.
- BIN_W, 9, width of readout bin counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  arm frames; sampled only in IDLE and at frame end.
- req0_valid  in  1  source 0 has a sample.
- req0_data  in  DATA_W  source 0 sample.
- req0_ready  out  1  source 0 sample accepted this cycle (combinational grant).
- req1_valid  in  1  source 1 has a sample.
- req1_data  in  DATA_W  source 1 sample.
- req1_ready  out  1  source 1 sample accepted this cycle.
- hist_ready  in  1  core can take a write this cycle.
- hist_write_en  out  1  registered write strobe to core.
- hist_data  out  DATA_W  registered sample to core.
- hist_valid_out  in  1  core readout bin valid.
- hist_last_bin  in  1  core readout final bin (qualified by `hist_valid_out`).
- frame_active  out  1  high in ACCEPT, DRAIN and READOUT.
- frame_done  out  1  one-cycle pulse after the last bin is seen.
- src0_count  out  CNT_W  samples accepted from source 0 in current frame.
- src1_count  out  CNT_W  samples accepted from source 1 in current frame.
- bins_seen  out  BIN_W  valid bins counted in current/last readout.
- proto_err  out  1  sticky; core readout seen outside DRAIN/READOUT.

Behaviour:
- Async reset values:
  - state = IDLE.
  - All counters and outputs = 0.
  - Round-robin pointer `last_grant` = 1, so source 0 wins the first tie.
- Grants are only possible in ACCEPT when `hist_ready` = 1.
  - Both valid: grant the source ≠ `last_grant`.
  - One valid: grant that source.
  - `last_grant` updates only on a grant.
  - At most one `reqN_ready` is high per cycle; both are 0 outside ACCEPT.
- Write latency is 1 cycle.
  - A grant in cycle t gives `hist_write_en` = 1 with `hist_data` = granted data in cycle t+1.
  - Otherwise `hist_write_en` = 0 and `hist_data` holds its last value.
- Frame and source counters:
  - Frame sample counter increments per grant.
  - `srcN_count` increments on its own grant and saturates at all-ones.
  - Counters clear on the IDLE→ACCEPT or READOUT→ACCEPT transition.
  - `srcN_count` and `bins_seen` hold their values in IDLE.
- State transitions:
  - IDLE → ACCEPT when `enable` = 1.
  - ACCEPT → DRAIN on the grant that makes sample count = `FRAME_LEN`. No grant occurs in the following cycle; the final `hist_write_en` still issues.
  - ACCEPT stays in ACCEPT if `enable` drops; `enable` is ignored mid-frame.
  - DRAIN → READOUT on the first `hist_valid_out`. That bin is counted; if `hist_last_bin` is also 1, go straight to frame end.
  - READOUT: `bins_seen` += 1 per `hist_valid_out`, saturating. On `hist_valid_out` && `hist_last_bin`: pulse `frame_done` next cycle, then go to ACCEPT if `enable` = 1, else IDLE.
- Protocol errors:
  - `hist_valid_out` in IDLE or ACCEPT sets `proto_err` and is otherwise ignored.
  - `proto_err` clears only on reset.
- `frame_active` = 1 in ACCEPT, DRAIN and READOUT.
- Reset mid-frame aborts immediately:
  - The write strobe is dropped in the same cycle (async).
  - Pending samples are not retained.

Test Plan:
- Only `req0_valid` = 1, `hist_ready` = 1, `FRAME_LEN` = 4 → `req0_ready` is high 4 consecutive cycles; 4 `hist_write_en` pulses each 1 cycle after grant; `src0_count` = 4, `src1_count` = 0; state DRAIN.
- Both valid, data 0x1110 / 0x2220 → `hist_data` alternates 0x1110, 0x2220, 0x1110, 0x2220; source 0 first; counts 2 / 2.
- `hist_ready` toggled 1,0,1,0 with both valid → grants only on ready cycles; no `hist_write_en` the cycle after a ready = 0.
- After frame, drive 5 `hist_valid_out` cycles with `hist_last_bin` on the 5th, `enable` = 0 → `bins_seen` = 5; `frame_done` pulses once; state IDLE; `frame_active` = 0.
- `hist_valid_out` = 1 during ACCEPT → `proto_err` = 1, remains 1 through next frame; `bins_seen` unaffected.
- `rst_n` low for 1 cycle mid-ACCEPT after 2 grants → all outputs 0 asynchronously; next frame starts from IDLE with counts 0 and source 0 winning the first tie.
